instr_prefetch_buffer: RTL and testbench

Fetch-side prefetch stage sitting directly upstream of the IF/ID pipeline register. It owns the program counter, fetches 8-bit instruction words from instruction memory over a req/ack handshake, and queues them in a small FIFO. The decode side pops them through a valid/ready interface. A redirect (taken jump/branch) flushes the queue and restarts fetch at a new address.

---
 rtl/proc_fetch_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 36 +++
 rtl/instr_prefetch_buffer.sv | 71 +++++++
 tb/tb_instr_prefetch_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_fetch_pkg.sv
// proc_fetch_pkg: shared fetch-stage types and constants
package proc_fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int RESET_PC = 0;
  typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO with flush (flush beats push)
module fetch_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // storage is cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (push && !flush)
      mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: PC/fetch FSM feeding a decode-side FIFO; PREFETCH_BYPASS_EN enables empty-queue bypass
module instr_prefetch_buffer
  import proc_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_Data,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_PC,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Instr,
  output logic [ADDR_W-1:0] Out_PC
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic empty, ack_ok, byp, pop_out, fifo_push, fifo_pop, fills;
  assign empty = count == '0;
  assign ack_ok = Mem_Req & Mem_Ack & ~Redirect;
`ifdef PREFETCH_BYPASS_EN
  assign byp = empty & ack_ok;
`else
  assign byp = 1'b0;
`endif
  assign Out_Valid = ~empty | byp;
  assign Out_Instr = byp ? Mem_Data : head[ADDR_W +: DATA_W];
  assign Out_PC = byp ? pc : head[ADDR_W-1:0];
  assign pop_out = Out_Valid & Out_Ready;
  assign fifo_pop = pop_out & ~empty;
  // a bypassed word taken by decode the same cycle never enters the queue
  assign fifo_push = ack_ok & ~(byp & Out_Ready);
  assign fills = fifo_push & ~fifo_pop & (count == CW'(DEPTH - 1));
  assign Mem_Addr = pc;
  always_ff @(posedge Clk)
    if (Reset) state <= S_RST;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:   state_nxt = S_FETCH;
      S_FETCH: state_nxt = (!Redirect && fills) ? S_HOLD : S_FETCH;
      S_HOLD:  state_nxt = (Redirect || pop_out) ? S_FETCH : S_HOLD;
      default: state_nxt = S_RST;
    endcase
  end
  always_comb Mem_Req = state == S_FETCH;
  always_ff @(posedge Clk)
    if (Reset) pc <= ADDR_W'(RESET_PC);
    else if (Redirect) pc <= Redirect_PC;
    else if (ack_ok) pc <= pc + 1'b1;
  fetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .flush(Redirect),
    .push(fifo_push),
    .pop(fifo_pop),
    .din({Mem_Data, pc}),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed + random checks against a queue-based fetch model
module tb_instr_prefetch_buffer;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic Clk = 0, Reset = 1, Mem_Ack = 0, Redirect = 0, Out_Ready = 0;
  logic [7:0] Redirect_PC = 0;
  logic Mem_Req, Out_Valid;
  logic [7:0] Mem_Addr, Mem_Data, Out_Instr, Out_PC;
  int n_tests = 0, n_fail = 0;

  function automatic logic [7:0] rom(input logic [7:0] a);
    return (a * 8'd13) ^ 8'h5A;
  endfunction

  assign Mem_Data = rom(Mem_Addr);
  always #5 Clk = ~Clk;

  instr_prefetch_buffer dut (
    .Clk(Clk), .Reset(Reset), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Instr(Out_Instr), .Out_PC(Out_PC)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [7:0] i; logic [7:0] p; } ent_t;
  ent_t q[$];
  logic [7:0] m_pc = 0;
  bit after_rst = 1, started = 0;
  bit m_req, m_ack, m_byp, m_pop;

  // model: a queue of fetched words, fetch allowed whenever the queue has room
  always @(posedge Clk) begin
    if (Reset) begin
      q.delete();
      m_pc = 0;
      after_rst = 1;
    end else begin
      m_req = !after_rst && q.size() < DEPTH;
      after_rst = 0;
      m_ack = m_req && Mem_Ack && !Redirect;
      m_byp = BYP && m_ack && q.size() == 0;
      m_pop = (q.size() > 0 || m_byp) && Out_Ready;
      if (Redirect) begin
        q.delete();
        m_pc = Redirect_PC;
      end else begin
        if (m_pop && q.size() > 0) void'(q.pop_front());
        if (m_ack && !(m_byp && Out_Ready)) q.push_back('{rom(m_pc), m_pc});
        if (m_ack) m_pc = m_pc + 8'd1;
      end
    end
    started = 1;
  end

  always @(negedge Clk) begin
    bit e_req, e_byp, e_val;
    if (started) begin
      e_req = !after_rst && q.size() < DEPTH;
      e_byp = BYP && q.size() == 0 && e_req && Mem_Ack && !Redirect;
      e_val = q.size() > 0 || e_byp;
      chk("mem_req", int'(Mem_Req), int'(e_req));
      chk("mem_addr", int'(Mem_Addr), int'(m_pc));
      chk("out_valid", int'(Out_Valid), int'(e_val));
      if (e_val && Out_Valid) begin
        chk("out_instr", int'(Out_Instr), int'(q.size() > 0 ? q[0].i : rom(m_pc)));
        chk("out_pc", int'(Out_PC), int'(q.size() > 0 ? q[0].p : m_pc));
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1; Mem_Ack = 0; Out_Ready = 0; Redirect = 0;
    tick; tick;
    Reset = 0;
    tick;
  endtask

  initial begin
    logic [7:0] exp;
    tick; tick;
    #1;
    chk("rst_req", int'(Mem_Req), 0);
    chk("rst_addr", int'(Mem_Addr), 0);
    chk("rst_valid", int'(Out_Valid), 0);
    chk("rst_instr", int'(Out_Instr), 0);
    chk("rst_pc", int'(Out_PC), 0);
    Reset = 0;
    tick;
    chk("start_req", int'(Mem_Req), 1);
    chk("start_addr", int'(Mem_Addr), 0);
    // streaming: one word per cycle after a one-cycle fill
    Mem_Ack = 1; Out_Ready = 1;
    tick;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stream_valid", int'(Out_Valid), 1);
      chk("stream_pc", int'(Out_PC), i + int'(BYP));
      chk("stream_instr", int'(Out_Instr), int'(rom(8'(i + int'(BYP)))));
      tick;
    end
    // fill to full then one pop
    do_reset;
    Mem_Ack = 1; Out_Ready = 0;
    repeat (6) tick;
    chk("full_req", int'(Mem_Req), 0);
    chk("full_addr", int'(Mem_Addr), 4);
    chk("full_head", int'(Out_PC), 0);
    Out_Ready = 1;
    tick;
    Out_Ready = 0;
    chk("refetch_req", int'(Mem_Req), 1);
    chk("refetch_addr", int'(Mem_Addr), 4);
    tick;
    chk("refull_req", int'(Mem_Req), 0);
    chk("refull_head", int'(Out_PC), 1);
    chk("refull_addr", int'(Mem_Addr), 5);
    // redirect with 3 queued and a coincident ack
    do_reset;
    Mem_Ack = 1; Out_Ready = 0;
    repeat (3) tick;
    Redirect = 1; Redirect_PC = 8'h40;
    tick;
    Redirect = 0; Mem_Ack = 0;
    chk("redir_valid", int'(Out_Valid), 0);
    chk("redir_addr", int'(Mem_Addr), 8'h40);
    chk("redir_req", int'(Mem_Req), 1);
    Mem_Ack = 1; Out_Ready = 1;
    tick;
    #1;
    chk("redir_head", int'(Out_PC), 8'h40 + int'(BYP));
    // wait-stated memory across the PC wrap
    do_reset;
    Out_Ready = 1; Redirect = 1; Redirect_PC = 8'hFE;
    tick;
    Redirect = 0;
    for (int w = 0; w < 3; w++) begin
      exp = 8'hFE + 8'(w);
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("wait_addr", int'(Mem_Addr), int'(exp));
        tick;
      end
      Mem_Ack = 1;
      tick;
      Mem_Ack = 0;
    end
    chk("wrap_addr", int'(Mem_Addr), 8'h01);
    // reset mid-request with two entries queued
    do_reset;
    Mem_Ack = 1; Out_Ready = 0;
    repeat (2) tick;
    Mem_Ack = 0;
    tick;
    Reset = 1; Mem_Ack = 1;
    tick;
    Reset = 0; Mem_Ack = 0;
    chk("midrst_req", int'(Mem_Req), 0);
    chk("midrst_addr", int'(Mem_Addr), 0);
    chk("midrst_valid", int'(Out_Valid), 0);
    chk("midrst_instr", int'(Out_Instr), 0);
    chk("midrst_pc", int'(Out_PC), 0);
    tick;
    chk("midrst_restart", int'(Mem_Req), 1);
    chk("midrst_restart_addr", int'(Mem_Addr), 0);
    // empty-queue ack latency
    do_reset;
    Mem_Ack = 1; Out_Ready = 1;
    #1;
    chk("byp_same_cycle", int'(Out_Valid), int'(BYP));
    tick;
    Mem_Ack = 0;
    #1;
    chk("byp_next_cycle", int'(Out_Valid), int'(!BYP));
    tick;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Mem_Ack = $urandom_range(0, 9) < 7;
      Out_Ready = $urandom_range(0, 9) < 6;
      Redirect = $urandom_range(0, 99) < 3;
      Redirect_PC = 8'($urandom);
      Reset = $urandom_range(0, 199) == 0;
      tick;
    end
    Reset = 0; Redirect = 0; Mem_Ack = 0; Out_Ready = 1;
    repeat (8) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
